// File: rtl/eight_demux.sv
// Receive-side 8:1 byte demultiplexer: rebuilds a frame of 8 bytes from a
// SYNC-aligned serial byte stream and commits it atomically to Q0..Q7.
module eight_demux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLOTW = 3
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             VDD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             SYNC,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [WIDTH-1:0] Q4,
    output logic [WIDTH-1:0] Q5,
    output logic [WIDTH-1:0] Q6,
    output logic [WIDTH-1:0] Q7,
    output logic [SLOTW-1:0] SLOT,
    output logic             FRAME_VALID,
    output logic             ERR
);

    localparam int unsigned NSLOT = 1 << SLOTW;
    localparam int unsigned LAST  = NSLOT - 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SLOTW-1:0] slot_q, slot_d;
    logic [WIDTH-1:0] shadow_q [LAST];
    logic [WIDTH-1:0] shadow_d [LAST];
    logic [WIDTH-1:0] q_q [NSLOT];
    logic [WIDTH-1:0] q_d [NSLOT];
    logic             fv_q, fv_d;
    logic             err_q, err_d;

    // State register; reset clears shadow, outputs and pulses.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            shadow_q <= '{default: '0};
            q_q      <= '{default: '0};
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            q_q      <= q_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    // Next state: the last slot bypasses the shadow and commits straight to Q.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        q_d      = q_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (EN && SYNC) begin
                    shadow_d[0] = D;
                    slot_d      = SLOTW'(1);
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (EN) begin
                    if (SYNC) begin
                        err_d       = 1'b1;
                        shadow_d[0] = D;
                        slot_d      = SLOTW'(1);
                    end else if (slot_q == SLOTW'(LAST)) begin
                        for (int n = 0; n < int'(LAST); n++) begin
                            q_d[n] = shadow_q[n];
                        end
                        q_d[LAST] = D;
                        fv_d      = 1'b1;
                        slot_d    = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        for (int n = 0; n < int'(LAST); n++) begin
                            if (slot_q == SLOTW'(n)) begin
                                shadow_d[n] = D;
                            end
                        end
                        slot_d = slot_q + SLOTW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs swing between the supply rail and ground.
    assign Q0          = q_q[0] & {WIDTH{VDD}};
    assign Q1          = q_q[1] & {WIDTH{VDD}};
    assign Q2          = q_q[2] & {WIDTH{VDD}};
    assign Q3          = q_q[3] & {WIDTH{VDD}};
    assign Q4          = q_q[4] & {WIDTH{VDD}};
    assign Q5          = q_q[5] & {WIDTH{VDD}};
    assign Q6          = q_q[6] & {WIDTH{VDD}};
    assign Q7          = q_q[7] & {WIDTH{VDD}};
    assign SLOT        = slot_q & {SLOTW{VDD}};
    assign FRAME_VALID = fv_q & VDD;
    assign ERR         = err_q & VDD;

endmodule

// File: tb/tb_eight_demux.sv
// Self-checking bench for eight_demux: directed scenarios plus a random
// stream, compared against a queue-based frame model.
module tb_eight_demux;

    logic       CK = 1'b0;
    logic       RST = 1'b0;
    logic       VDD = 1'b1;
    logic [7:0] D = 8'h00;
    logic       EN = 1'b0;
    logic       SYNC = 1'b0;
    logic [7:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
    logic [2:0] SLOT;
    logic       FRAME_VALID;
    logic       ERR;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [8];
    logic [7:0] frame [$];
    logic       exp_fv;
    logic       exp_err;
    int         fv_count;
    int         err_count;

    eight_demux dut (
        .CK(CK), .RST(RST), .VDD(VDD), .D(D), .EN(EN), .SYNC(SYNC),
        .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7),
        .SLOT(SLOT), .FRAME_VALID(FRAME_VALID), .ERR(ERR)
    );

    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] obs [8];
        obs = '{Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s Q%0d", tag, i), obs[i], exp_q[i]);
        end
        check({tag, " SLOT"}, 8'(SLOT), 8'(frame.size()));
        check({tag, " FRAME_VALID"}, 8'(FRAME_VALID), 8'(exp_fv));
        check({tag, " ERR"}, 8'(ERR), 8'(exp_err));
    endtask

    // Frame model: a partial frame is the queue of bytes since the last SYNC.
    task automatic model(input logic rst, input logic en, input logic sync, input logic [7:0] d);
        exp_fv  = 1'b0;
        exp_err = 1'b0;
        if (rst) begin
            frame.delete();
            for (int i = 0; i < 8; i++) exp_q[i] = 8'h00;
        end else if (en) begin
            if (sync) begin
                if (frame.size() != 0) exp_err = 1'b1;
                frame.delete();
                frame.push_back(d);
            end else if (frame.size() != 0) begin
                frame.push_back(d);
                if (frame.size() == 8) begin
                    for (int i = 0; i < 8; i++) exp_q[i] = frame[i];
                    frame.delete();
                    exp_fv = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input string tag, input logic rst, input logic en,
                       input logic sync, input logic [7:0] d);
        RST = rst; EN = en; SYNC = sync; D = d;
        @(posedge CK);
        #1;
        model(rst, en, sync, d);
        if (FRAME_VALID) fv_count++;
        if (ERR) err_count++;
        check_all(tag);
    endtask

    task automatic idle_gap(input string tag, input int n);
        for (int g = 0; g < n; g++) cyc(tag, 1'b0, 1'b0, (($urandom & 1) != 0), 8'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp_q[i] = 8'h00;
        exp_fv = 1'b0; exp_err = 1'b0;
        fv_count = 0; err_count = 0;

        cyc("reset", 1'b1, 1'b0, 1'b0, 8'h00);
        cyc("reset", 1'b1, 1'b1, 1'b1, 8'hFF);

        // Basic frame
        fv_count = 0;
        cyc("basic", 1'b0, 1'b1, 1'b1, 8'h10);
        for (int i = 1; i < 8; i++) cyc("basic", 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        cyc("basic tail", 1'b0, 1'b0, 1'b0, 8'h00);
        check("basic fv count", 8'(fv_count), 8'd1);

        // Gapped frame with identical bytes
        fv_count = 0;
        for (int i = 0; i < 8; i++) begin
            cyc("gapped", 1'b0, 1'b1, (i == 0), 8'(8'h10 + i));
            idle_gap("gapped gap", int'($urandom_range(1, 3)));
        end
        check("gapped fv count", 8'(fv_count), 8'd1);

        // Unaligned bytes in IDLE are dropped
        for (int i = 0; i < 5; i++) cyc("unaligned", 1'b0, 1'b1, 1'b0, 8'hAA);

        // Resync mid-frame
        err_count = 0; fv_count = 0;
        cyc("resync", 1'b0, 1'b1, 1'b1, 8'h30);
        for (int i = 1; i < 4; i++) cyc("resync", 1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
        cyc("resync sync", 1'b0, 1'b1, 1'b1, 8'h20);
        for (int i = 1; i < 8; i++) cyc("resync", 1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        cyc("resync tail", 1'b0, 1'b0, 1'b0, 8'h00);
        check("resync err count", 8'(err_count), 8'd1);
        check("resync fv count", 8'(fv_count), 8'd1);

        // Reset at SLOT=5, then a full frame
        fv_count = 0;
        cyc("midrst", 1'b0, 1'b1, 1'b1, 8'h50);
        for (int i = 1; i < 5; i++) cyc("midrst", 1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
        cyc("midrst rst", 1'b1, 1'b1, 1'b0, 8'h55);
        check("midrst fv count", 8'(fv_count), 8'd0);
        for (int i = 0; i < 8; i++) cyc("after rst", 1'b0, 1'b1, (i == 0), 8'(8'h40 + i));
        check("after rst fv count", 8'(fv_count), 8'd1);

        // Random stream: sparse SYNC, random gaps, rare reset
        for (int k = 0; k < 600; k++) begin
            cyc("random", ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0), 8'($urandom));
        end

        // Output rails follow the supply
        VDD = 1'b0;
        #1;
        check("vdd low Q7", Q7, 8'h00);
        check("vdd low SLOT", 8'(SLOT), 8'h00);
        VDD = 1'b1;
        #1;
        check_all("vdd restored");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
